// File: rtl/ps2_key_decoder_if.sv
// Bus between the PS/2 pins, the key decoder and the game control block.
// The decoder sits on the master modport; the pins and consumer side use slave.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic [7:0] scan_code;
  logic       byte_valid;
  logic       frame_err;
  logic       rx_state_dbg;
  logic [1:0] dec_state_dbg;

  // byte_valid and frame_err are single-cycle strobes with no ready: scan_code is
  // valid in the cycle byte_valid is high and holds until the next good byte.
  modport master (
    input  ps2_clk, ps2_data,
    output key_space, key_left, key_right, scan_code, byte_valid, frame_err,
    output rx_state_dbg, dec_state_dbg
  );
  modport slave (
    output ps2_clk, ps2_data,
    input  key_space, key_left, key_right, scan_code, byte_valid, frame_err,
    input  rx_state_dbg, dec_state_dbg
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 receiver and make/break decoder producing held-key levels for space/left/right.
// Define KBD_WASD_EN to also drive key_left/key_right from the A and D keys.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_key_decoder_if.master    bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic       {RX_IDLE, RX_BITS} rx_state_e;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_e;

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_edge, timeout;
  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
  dec_state_e    dec_state_q, dec_state_d;
  logic          space_q, space_d, left_arrow_q, left_arrow_d, right_arrow_q, right_arrow_d;
`ifdef KBD_WASD_EN
  logic          left_letter_q, left_letter_d, right_letter_q, right_letter_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      data_meta_q   <= 1'b1;
      data_sync_q   <= 1'b1;
      filt_q        <= 1'b1;
      filt_cnt_q    <= '0;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      to_cnt_q      <= '0;
      scan_code_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      dec_state_q   <= D_IDLE;
      space_q       <= 1'b0;
      left_arrow_q  <= 1'b0;
      right_arrow_q <= 1'b0;
`ifdef KBD_WASD_EN
      left_letter_q  <= 1'b0;
      right_letter_q <= 1'b0;
`endif
    end else begin
      clk_meta_q    <= bus.ps2_clk;
      clk_sync_q    <= clk_meta_q;
      data_meta_q   <= bus.ps2_data;
      data_sync_q   <= data_meta_q;
      filt_q        <= filt_d;
      filt_cnt_q    <= filt_cnt_d;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      to_cnt_q      <= to_cnt_d;
      scan_code_q   <= scan_code_d;
      byte_valid_q  <= byte_valid_d;
      frame_err_q   <= frame_err_d;
      dec_state_q   <= dec_state_d;
      space_q       <= space_d;
      left_arrow_q  <= left_arrow_d;
      right_arrow_q <= right_arrow_d;
`ifdef KBD_WASD_EN
      left_letter_q  <= left_letter_d;
      right_letter_q <= right_letter_d;
`endif
    end
  end

  // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall_edge = filt_q & ~filt_d;
  assign timeout   = (rx_state_q == RX_BITS) && !fall_edge &&
                     (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (fall_edge && !data_sync_q) rx_state_d = RX_BITS;
      RX_BITS: if ((fall_edge && bit_cnt_q == 4'd10) || timeout) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Shift register holds data bits 1-8 and parity; the stop bit is checked live.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = '0;
    scan_code_d  = scan_code_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (fall_edge && !data_sync_q) bit_cnt_d = 4'd1;
      RX_BITS: begin
        if (fall_edge) begin
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            if ((^shift_q) && data_sync_q) begin
              scan_code_d  = shift_q[7:0];
              byte_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d   = {data_sync_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout) begin
          bit_cnt_d   = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: bit_cnt_d = '0;
    endcase
  end

  always_comb begin
    dec_state_d = dec_state_q;
    if (byte_valid_q) begin
      case (dec_state_q)
        D_IDLE: begin
          if (scan_code_q == 8'hE0)      dec_state_d = D_EXT;
          else if (scan_code_q == 8'hF0) dec_state_d = D_BRK;
        end
        D_EXT:   dec_state_d = (scan_code_q == 8'hF0) ? D_EXT_BRK : D_IDLE;
        default: dec_state_d = D_IDLE;
      endcase
    end
  end

  always_comb begin
    space_d       = space_q;
    left_arrow_d  = left_arrow_q;
    right_arrow_d = right_arrow_q;
`ifdef KBD_WASD_EN
    left_letter_d  = left_letter_q;
    right_letter_d = right_letter_q;
`endif
    if (byte_valid_q) begin
      case (dec_state_q)
        D_IDLE: begin
          if (scan_code_q == 8'h29) space_d = 1'b1;
`ifdef KBD_WASD_EN
          if (scan_code_q == 8'h1C) left_letter_d  = 1'b1;
          if (scan_code_q == 8'h23) right_letter_d = 1'b1;
`endif
        end
        D_EXT: begin
          if (scan_code_q == 8'h6B) left_arrow_d  = 1'b1;
          if (scan_code_q == 8'h74) right_arrow_d = 1'b1;
        end
        D_BRK: begin
          if (scan_code_q == 8'h29) space_d = 1'b0;
`ifdef KBD_WASD_EN
          if (scan_code_q == 8'h1C) left_letter_d  = 1'b0;
          if (scan_code_q == 8'h23) right_letter_d = 1'b0;
`endif
        end
        default: begin
          if (scan_code_q == 8'h6B) left_arrow_d  = 1'b0;
          if (scan_code_q == 8'h74) right_arrow_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.key_space     = space_q;
`ifdef KBD_WASD_EN
  assign bus.key_left      = left_arrow_q | left_letter_q;
  assign bus.key_right     = right_arrow_q | right_letter_q;
`else
  assign bus.key_left      = left_arrow_q;
  assign bus.key_right     = right_arrow_q;
`endif
  assign bus.scan_code     = scan_code_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.rx_state_dbg  = rx_state_q;
  assign bus.dec_state_dbg = dec_state_q;
endmodule
